fwd_scoreboard: RTL
===================

Name: fwd_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the execute stage. It serves NREAD register read ports and tracks DEPTH in-flight writeback stages.
- The block owns a registered shadow pipeline of the destination register, data and readiness of every instruction past EX (entry 0 = MEM, entry 1 = WB, deeper entries = commit buffer). It resolves forwarding youngest-first from this pipeline.
- It raises a stall on load-use and on multi-cycle memory waits. It counts stall cycles for performance monitoring.

Parameters:
- NREAD, 2, number of EX read ports.
- DEPTH, 3, tracked stages after EX (minimum 2).
- RW, 7, register-number width.
- DW, 32, data width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- rd_num  in  NREAD*RW  per-port source register number; port p occupies bits [p*RW +: RW].
- rd_rf_data  in  NREAD*DW  per-port register-file value.
- rd_data  out  NREAD*DW  per-port resolved operand.
- fwd_hit  out  NREAD  per-port flag: operand taken from the shadow pipeline.
- ex_wen  in  1  EX instruction writes a register.
- ex_rd  in  RW  EX destination register.
- ex_is_load  in  1  EX instruction is a load.
- ex_alu_data  in  DW  EX ALU result.
- flush  in  1  kill the EX instruction (bubble into entry 0).
- mem_ld_valid  in  1  load data for entry 0 is present this cycle.
- mem_ld_data  in  DW  load data.
- load_use  out  1  a port needs a non-ready entry.
- mem_wait  out  1  entry 0 is a load without data.
- ex_stall  out  1  load_use | mem_wait; hold IF/ID/EX.
- stall_cnt  out  32  saturating count of cycles with ex_stall=1.

Behaviour:
- Entry fields: v, rd, ld, rdy, data. Reset clears all v, rd, ld, rdy and data to 0, and sets stall_cnt to 0. After reset all outputs are combinational from the cleared state: rd_data = rd_rf_data, fwd_hit = 0, stalls = 0.
- mem_wait = e0.v & e0.ld & ~e0.rdy & ~mem_ld_valid.
- Port match, entry k: e[k].v & (e[k].rd == rd_num[p]) & (rd_num[p] != 0). The lowest k wins (youngest instruction).
- Matched entry with rdy=1: rd_data = e[k].data, fwd_hit = 1.
- Matched entry with rdy=0: load_use = 1; rd_data = rd_rf_data and fwd_hit = 0 (don't-care, but fixed for checking).
- No match: rd_data = rd_rf_data, fwd_hit = 0.
- Same-cycle load data is never forwarded combinationally; a load still stalls its consumer for one cycle.
- Register number 0 never matches and never stalls.
- Clock update, priority order:
  - mem_wait = 1: freeze. All entries hold; load_use is still reported.
  - Otherwise advance. For k ≥ 1, e[k] <= e[k-1], except that if e0 is a not-ready load then e1 takes data = mem_ld_data and rdy = 1. Entry DEPTH-1 is retired.
  - Entry 0 gets a bubble (v = 0) if load_use | flush | ~ex_wen.
  - Otherwise entry 0 gets {1, ex_rd, ex_is_load, rdy = ~ex_is_load, ex_alu_data}.
- A load-use bubble lets the load move to entry 1 with rdy = 1. The held EX instruction then forwards from entry 1 on the next cycle, so the exact penalty is 1 cycle (plus any mem_wait cycles).
- flush together with load_use: bubble, identical result.
- flush during mem_wait: ignored. The upstream stage must hold flush until ex_stall = 0.
- stall_cnt increments on every clk edge with ex_stall = 1 and saturates at 0xFFFFFFFF.
- Reset asserted mid-operation clears all entries and stall_cnt immediately, independent of clk.
- Latency: outputs are combinational from registered state plus inputs. There is no path from mem_ld_data to rd_data.

Test Plan:
- Back-to-back ALU ops: write r5 = 0x11 then r5 = 0x22. A consumer reading r5 must get 0x22 (entry 0 beats entry 1), with fwd_hit = 1 and no stall.
- Load r3 followed by a consumer of r3, mem_ld_valid = 1 with data 0xCAFE: load_use = 1 for exactly 1 cycle and stall_cnt = 1. Next cycle rd_data = 0xCAFE via entry 1.
- Load with mem_ld_valid low for 3 cycles: mem_wait = 1 and the entries stay frozen for 3 cycles. Then data 0xBEEF arrives and the dependent forwarding yields 0xBEEF; stall_cnt = 4 counting the load-use cycle.
- Reads of r0 while entry 0 is an unready load to r0: rd_data = rd_rf_data, fwd_hit = 0, load_use = 0.
- Write r9 = 0x33 with flush = 1: nothing enters entry 0, and a later read of r9 returns rd_rf_data.
- Assert rst_n low between clk edges with entries valid and stall_cnt = 7: v clears and stall_cnt = 0 at once. Next a write r4 = 0x44 to port 1 only, with DEPTH = 4 and NREAD = 3: the value is forwarded through entries 0..3 and disappears on the 4th advance.

Source files
------------

// File: rtl/fwd_scoreboard.sv
// Execute-stage forwarding and hazard unit.
// Shadows MEM/WB/commit destinations and resolves operands youngest-first.
module fwd_scoreboard #(
    parameter int NREAD = 2,
    parameter int DEPTH = 3,
    parameter int RW    = 7,
    parameter int DW    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREAD*RW-1:0] rd_num,
    input  logic [NREAD*DW-1:0] rd_rf_data,
    output logic [NREAD*DW-1:0] rd_data,
    output logic [NREAD-1:0]    fwd_hit,
    input  logic                ex_wen,
    input  logic [RW-1:0]       ex_rd,
    input  logic                ex_is_load,
    input  logic [DW-1:0]       ex_alu_data,
    input  logic                flush,
    input  logic                mem_ld_valid,
    input  logic [DW-1:0]       mem_ld_data,
    output logic                load_use,
    output logic                mem_wait,
    output logic                ex_stall,
    output logic [31:0]         stall_cnt
);

    logic [DEPTH-1:0] e_v;
    logic [DEPTH-1:0] e_ld;
    logic [DEPTH-1:0] e_rdy;
    logic [RW-1:0]    e_rd   [DEPTH];
    logic [DW-1:0]    e_data [DEPTH];

    logic [NREAD-1:0] p_hit;
    logic [NREAD-1:0] p_rdy;
    logic [DW-1:0]    p_data [NREAD];

    logic ld_pending;
    logic bubble;
    logic unused_ld;

    // Only the MEM entry's load flag matters once loads complete.
    assign unused_ld = ^e_ld[DEPTH-1:1];

    assign ld_pending = e_v[0] & e_ld[0] & ~e_rdy[0];
    assign mem_wait   = ld_pending & ~mem_ld_valid;
    assign ex_stall   = load_use | mem_wait;
    assign bubble     = load_use | flush | ~ex_wen;

    // Per-port match search; scanning oldest to youngest lets entry 0 win.
    always_comb begin
        p_hit = '0;
        p_rdy = '0;
        for (int p = 0; p < NREAD; p++) begin
            p_data[p] = '0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (e_v[k] && (e_rd[k] == rd_num[p*RW +: RW])
                    && (rd_num[p*RW +: RW] != '0)) begin
                    p_hit[p]  = 1'b1;
                    p_rdy[p]  = e_rdy[k];
                    p_data[p] = e_data[k];
                end
            end
        end
    end

    // Operand mux and load-use detection from the match results.
    always_comb begin
        rd_data  = rd_rf_data;
        fwd_hit  = '0;
        load_use = 1'b0;
        for (int p = 0; p < NREAD; p++) begin
            if (p_hit[p] && p_rdy[p]) begin
                rd_data[p*DW +: DW] = p_data[p];
                fwd_hit[p]          = 1'b1;
            end
            if (p_hit[p] && !p_rdy[p]) begin
                load_use = 1'b1;
            end
        end
    end

    // Shadow pipeline: freeze on mem_wait, else shift and insert EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_v   <= '0;
            e_ld  <= '0;
            e_rdy <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                e_rd[k]   <= '0;
                e_data[k] <= '0;
            end
        end else if (!mem_wait) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                e_v[k]    <= e_v[k-1];
                e_ld[k]   <= e_ld[k-1];
                e_rdy[k]  <= e_rdy[k-1];
                e_rd[k]   <= e_rd[k-1];
                e_data[k] <= e_data[k-1];
            end
            if (ld_pending) begin
                e_rdy[1]  <= 1'b1;
                e_data[1] <= mem_ld_data;
            end
            if (bubble) begin
                e_v[0]    <= 1'b0;
                e_ld[0]   <= 1'b0;
                e_rdy[0]  <= 1'b0;
                e_rd[0]   <= '0;
                e_data[0] <= '0;
            end else begin
                e_v[0]    <= 1'b1;
                e_ld[0]   <= ex_is_load;
                e_rdy[0]  <= ~ex_is_load;
                e_rd[0]   <= ex_rd;
                e_data[0] <= ex_alu_data;
            end
        end
    end

    // Saturating stall-cycle counter for performance monitoring.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (ex_stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule
